spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_ctrl_pkg.sv | 7 +
 rtl/spi_rr_arb.sv | 20 ++
 rtl/spi_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared FSM state type and default sizing for the SPI arbiter
package spi_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, XFER, DONE} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_TIMEOUT_CYC = 16;
endpackage

// File: rtl/spi_rr_arb.sv
// spi_rr_arb: combinational round-robin pick, first set req at or above ptr with wrap
module spi_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_oh,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        idx = '0;
        any = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
        gnt_oh = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master among NUM_REQ requesters
module spi_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_tx_data,
    input  logic [DATA_W-1:0]         spi_rx_data,
    input  logic                      spi_busy,
    output logic                      ctrl_busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr, pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;

    spi_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign timeout   = state == WAIT_BUSY && !spi_busy && cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign spi_start = state == START;
    assign ctrl_busy = state != IDLE;
    assign rsp_valid = state == DONE ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = pick_any ? START : IDLE;
            START:     state_n = WAIT_BUSY;
            WAIT_BUSY: state_n = spi_busy ? XFER : timeout ? DONE : WAIT_BUSY;
            XFER:      state_n = spi_busy ? XFER : DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // gnt doubles as the latched requester index; it drops on the DONE->IDLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            gnt         <= '0;
            spi_tx_data <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cnt         <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt         <= pick_oh;
                spi_tx_data <= req_data[pick_idx*DATA_W +: DATA_W];
                rr_ptr      <= pick_idx == IDX_W'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
            end
            if (state == DONE) gnt <= '0;
            if (state == START) cnt <= '0;
            if (state == WAIT_BUSY && !spi_busy && !timeout) cnt <= cnt + 1'b1;
            if (timeout) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
            if (state == XFER && !spi_busy) begin
                rsp_data <= spi_rx_data;
                rsp_err  <= 1'b0;
            end
        end
    end
endmodule
